imem_port_arbiter: RTL and testbench

//  Shares one single-ported word memory between the instruction-fetch requester (F, driven by IF)
//  and the load/store requester (D, driven by the MEM stage).

---
 rtl/imem_arb_pkg.sv | 17 +
 rtl/arb_streak_limiter.sv | 39 +++
 rtl/imem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction/data memory port arbiter
package imem_arb_pkg;

  localparam int IMEM_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_F = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_streak_limiter.sv
// rtl/arb_streak_limiter.sv - counts back-to-back D grants while F waits and forces an F grant at the limit
module arb_streak_limiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic f_gnt,
  input  logic d_gnt,
  output logic force_f
);

  localparam int CNT_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] streak_cnt_q;
  logic [CNT_W-1:0] streak_cnt_d;

  // Streak only builds while F is actually kept waiting.
  always_comb begin
    streak_cnt_d = streak_cnt_q;
    if (f_gnt || !f_req) begin
      streak_cnt_d = '0;
    end else if (d_gnt && (streak_cnt_q != CNT_MAX)) begin
      streak_cnt_d = streak_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_cnt_q <= '0;
    end else begin
      streak_cnt_q <= streak_cnt_d;
    end
  end

  assign force_f = (streak_cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one word memory between fetch (F) and load/store (D); IMEM_ARB_PERF_EN adds perf counters
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  output logic              f_stall,
  output logic              d_stall
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       d_win_cnt
`endif
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     owner_q;
  owner_e     owner_d;
  owner_e     winner;

  logic force_f;
  logic idle;
  logic issue;
  logic sel_f;
  logic sel_d;
  logic rsp;

  arb_streak_limiter #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .f_gnt  (f_gnt),
    .d_gnt  (d_gnt),
    .force_f(force_f)
  );

  assign idle   = (state_q == IDLE);
  assign winner = (d_req && !(f_req && force_f)) ? OWN_D : OWN_F;

  // A reset cycle behaves as IDLE for m_req but never issues or responds.
  assign m_req = (idle || rst) && (f_req || d_req);
  assign issue = idle && !rst && (f_req || d_req) && m_gnt;
  assign sel_f = idle && !rst && f_req && (winner == OWN_F);
  assign sel_d = idle && !rst && d_req && (winner == OWN_D);

  assign f_gnt   = issue && (winner == OWN_F);
  assign d_gnt   = issue && (winner == OWN_D);
  assign m_we    = sel_d && d_we;
  assign m_be    = sel_d ? d_be : 4'b0000;
  assign m_wdata = sel_d ? d_wdata : 32'd0;
  assign m_addr  = sel_f ? f_addr : (sel_d ? d_addr : '0);

  // m_rvalid seen in IDLE is a stale response and is dropped.
  assign rsp      = !rst && !idle && m_rvalid;
  assign f_rvalid = rsp && (owner_q == OWN_F);
  assign d_rvalid = rsp && (owner_q == OWN_D);
  assign f_rdata  = f_rvalid ? m_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? m_rdata : 32'd0;

  assign f_stall = f_req && !f_rvalid;
  assign d_stall = d_req && !d_rvalid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          owner_d = winner;
          state_d = (winner == OWN_D) ? WAIT_D : WAIT_F;
        end
      end
      WAIT_F, WAIT_D: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_F;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] conflict_cnt_d;
  logic [31:0] d_win_cnt_q;
  logic [31:0] d_win_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + ((idle && f_req && d_req) ? 32'd1 : 32'd0);
    d_win_cnt_d    = d_win_cnt_q + (d_gnt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 32'd0;
      d_win_cnt_q    <= 32'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      d_win_cnt_q    <= d_win_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign d_win_cnt    = d_win_cnt_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench: requester queues, latency-programmable memory, response scoreboard
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = IMEM_ADDR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, d_req, d_we, m_gnt, m_rvalid;
  logic [AW-1:0] f_addr, d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata, m_rdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, m_req, m_we, f_stall, d_stall;
  logic [31:0]   f_rdata, d_rdata, m_wdata;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt, d_win_cnt;
`endif

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .f_stall(f_stall), .d_stall(d_stall)
`ifdef IMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .d_win_cnt(d_win_cnt)
`endif
  );

  a_f_hold: assert property (@(posedge clk) disable iff (rst) (f_req && !f_gnt) |=> f_req)
    else $error("f_req dropped before f_gnt");
  a_d_hold: assert property (@(posedge clk) disable iff (rst) (d_req && !d_gnt) |=> d_req)
    else $error("d_req dropped before d_gnt");

  typedef struct { bit is_d; bit is_wr; logic [31:0] data; } exp_t;
  typedef struct { bit we; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] wdata; } dop_t;
  typedef struct {
    bit f; logic [AW-1:0] fa;
    bit d; bit we; logic [3:0] be; logic [AW-1:0] da; logic [31:0] wd;
    int lat; bit first_d;
  } vec_t;

  exp_t          exp_q[$];
  logic [AW-1:0] f_q[$];
  dop_t          d_q[$];
  bit            gnt_log[$];
  logic [31:0]   dev_mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  vec_t          vecs[8];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit gnt_en = 1'b1;
  int mem_lat = 1;
  bit pend_valid = 1'b0;
  int pend_cd = 0;
  logic [31:0] pend_data = 32'd0;

  logic          s_f_gnt, s_d_gnt, s_f_rvalid, s_d_rvalid, s_m_req, s_m_we, s_f_stall, s_d_stall, s_f_req;
  logic [31:0]   s_f_rdata, s_d_rdata;
  logic [3:0]    s_m_be;
  logic [AW-1:0] s_m_addr;

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_reqs();
    f_req  = (f_q.size() > 0);
    f_addr = f_req ? f_q[0] : '0;
    d_req  = (d_q.size() > 0);
    if (d_req) begin
      d_we = d_q[0].we; d_be = d_q[0].be; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
    end else begin
      d_we = 1'b0; d_be = 4'b0; d_addr = '0; d_wdata = 32'd0;
    end
  endtask

  // One clock cycle: settle, score, let the memory accept, then advance past the edge.
  task automatic tick();
    exp_t e;
    drive_reqs();
    m_gnt = gnt_en;
    #1;
    s_f_gnt = f_gnt; s_d_gnt = d_gnt; s_f_rvalid = f_rvalid; s_d_rvalid = d_rvalid;
    s_f_rdata = f_rdata; s_d_rdata = d_rdata; s_m_req = m_req; s_m_we = m_we;
    s_m_be = m_be; s_m_addr = m_addr; s_f_stall = f_stall; s_d_stall = d_stall; s_f_req = f_req;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (f_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rv_owner", {30'd0, f_rvalid, d_rvalid}, {30'd0, !e.is_d, e.is_d});
          if (!e.is_wr) chk("rv_rdata", e.is_d ? d_rdata : f_rdata, e.data);
        end
      end
      if (f_gnt && d_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (f_gnt || d_gnt) begin
        gnt_log.push_back(d_gnt);
        if (d_gnt) begin
          chk("gnt_m_addr_d", 32'(m_addr), 32'(d_addr));
          chk("gnt_m_we_d", 32'(m_we), 32'(d_we));
          e.is_d = 1'b1; e.is_wr = d_we; e.data = 32'd0;
          if (d_we) begin
            chk("gnt_m_be", 32'(m_be), 32'(d_be));
            chk("gnt_m_wdata", m_wdata, d_wdata);
            ref_mem[d_addr] = merge(ref_mem[d_addr], d_wdata, d_be);
          end else begin
            e.data = ref_mem[d_addr];
          end
        end else begin
          chk("gnt_m_addr_f", 32'(m_addr), 32'(f_addr));
          chk("gnt_m_we_f", 32'(m_we), 32'd0);
          e.is_d = 1'b0; e.is_wr = 1'b0; e.data = ref_mem[f_addr];
        end
        exp_q.push_back(e);
      end
    end
    if (m_req && m_gnt && !rst) begin
      if (m_we) dev_mem[m_addr] = merge(dev_mem[m_addr], m_wdata, m_be);
      pend_data = dev_mem[m_addr]; pend_valid = 1'b1; pend_cd = mem_lat;
    end
    @(posedge clk);
    #1;
    m_rvalid = 1'b0; m_rdata = 32'd0;
    if (pend_valid) begin
      pend_cd--;
      if (pend_cd <= 0) begin
        m_rvalid = 1'b1; m_rdata = pend_data; pend_valid = 1'b0;
      end
    end
    if (s_f_gnt) void'(f_q.pop_front());
    if (s_d_gnt) void'(d_q.pop_front());
    drive_reqs();
  endtask

  task automatic drain(input int bound, input string name);
    int n;
    bit busy;
    n = 0;
    busy = (f_q.size() > 0) || (d_q.size() > 0) || (exp_q.size() > 0) || pend_valid;
    while (busy && n < bound) begin
      tick();
      n++;
      busy = (f_q.size() > 0) || (d_q.size() > 0) || (exp_q.size() > 0) || pend_valid;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic push_d(input bit we, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] wd);
    dop_t op;
    op.we = we; op.be = be; op.addr = a; op.wdata = wd;
    d_q.push_back(op);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int first;
    logic [6:0] order;
    for (int a = 0; a < (1 << AW); a++) begin
      dev_mem[a] = init_val(AW'(a));
      ref_mem[a] = init_val(AW'(a));
    end
    vecs[0] = '{1'b1, 14'h010, 1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1, 1'b0};
    vecs[1] = '{1'b0, 14'h000, 1'b1, 1'b0, 4'h0, 14'h020, 32'h0, 2, 1'b1};
    vecs[2] = '{1'b0, 14'h000, 1'b1, 1'b1, 4'h3, 14'h030, 32'hAABBCCDD, 1, 1'b1};
    vecs[3] = '{1'b1, 14'h030, 1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1, 1'b0};
    vecs[4] = '{1'b1, 14'h040, 1'b1, 1'b0, 4'h0, 14'h041, 32'h0, 3, 1'b1};
    vecs[5] = '{1'b0, 14'h000, 1'b1, 1'b1, 4'hC, 14'h030, 32'h11223344, 2, 1'b1};
    vecs[6] = '{1'b0, 14'h000, 1'b1, 1'b0, 4'h0, 14'h030, 32'h0, 1, 1'b1};
    vecs[7] = '{1'b1, 14'h3FFF, 1'b1, 1'b1, 4'hF, 14'h3FFF, 32'h0BADF00D, 1, 1'b1};

    rst = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = 32'd0;
    drive_reqs();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", {24'd0, s_f_gnt, s_d_gnt, s_f_rvalid, s_d_rvalid, s_m_req, s_m_we, s_f_stall, s_d_stall}, 32'd0);

    // Fetch-only read, memory latency 1.
    mem_lat = 1;
    f_q.push_back(14'h010);
    tick();
    chk("t1_f_gnt", 32'(s_f_gnt), 32'd1);
    chk("t1_d_gnt", 32'(s_d_gnt), 32'd0);
    tick();
    chk("t1_f_rvalid", 32'(s_f_rvalid), 32'd1);
    chk("t1_f_rdata", s_f_rdata, init_val(14'h010));
    chk("t1_d_rvalid", 32'(s_d_rvalid), 32'd0);
    drain(20, "t1_drain");
    tick();

    // Partial write, latency 2.
    mem_lat = 2;
    push_d(1'b1, 4'b0011, 14'h030, 32'hAABBCCDD);
    tick();
    chk("t3_d_gnt", 32'(s_d_gnt), 32'd1);
    chk("t3_m_we", 32'(s_m_we), 32'd1);
    chk("t3_m_be", 32'(s_m_be), 32'h3);
    cnt = 0;
    while (!(s_f_rvalid || s_d_rvalid) && cnt < 10) begin tick(); cnt++; end
    chk("t3_d_rvalid", 32'(s_d_rvalid), 32'd1);
    chk("t3_f_rvalid", 32'(s_f_rvalid), 32'd0);
    drain(20, "t3_drain");
    tick();

    for (int i = 0; i < 8; i++) begin
      mem_lat = vecs[i].lat;
      gnt_log.delete();
      if (vecs[i].f) f_q.push_back(vecs[i].fa);
      if (vecs[i].d) push_d(vecs[i].we, vecs[i].be, vecs[i].da, vecs[i].wd);
      drain(60, "vec_drain");
      first = (gnt_log.size() > 0) ? int'(gnt_log[0]) : -1;
      chk("vec_first_owner", 32'(first), 32'(vecs[i].first_d));
      chk("vec_n_gnt", 32'(gnt_log.size()), 32'(int'(vecs[i].f) + int'(vecs[i].d)));
      tick();
    end

    // D streak limit with F waiting.
    mem_lat = 1;
    gnt_log.delete();
    f_q.push_back(14'h050);
    for (int k = 0; k < 6; k++) push_d(1'b0, 4'h0, AW'(14'h100 + k), 32'd0);
    cnt = 0;
    while ((f_q.size() > 0 || d_q.size() > 0 || exp_q.size() > 0 || pend_valid) && cnt < 60) begin
      tick();
      cnt++;
      if (s_d_gnt && s_f_req) chk("t2_f_stall", 32'(s_f_stall), 32'd1);
    end
    chk("t2_n_gnt", 32'(gnt_log.size()), 32'd7);
    order = '0;
    for (int k = 0; k < 7 && k < gnt_log.size(); k++) order[6-k] = gnt_log[k];
    chk("t2_order", 32'(order), 32'b1111011);
    tick();

    // Memory holds off m_gnt.
    gnt_en = 1'b0;
    f_q.push_back(14'h060);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_m_req", 32'(s_m_req), 32'd1);
      chk("t5_m_addr", 32'(s_m_addr), 32'h060);
      chk("t5_f_stall", 32'(s_f_stall), 32'd1);
      chk("t5_f_gnt", 32'(s_f_gnt), 32'd0);
    end
    gnt_en = 1'b1;
    drain(20, "t5_drain");
    tick();

    // Reset while waiting on a D read; the late response must be dropped.
    mem_lat = 3;
    push_d(1'b0, 4'h0, 14'h070, 32'd0);
    cnt = 0;
    s_d_gnt = 1'b0;
    while (!s_d_gnt && cnt < 10) begin tick(); cnt++; end
    chk("t4_d_gnt", 32'(s_d_gnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_d_rvalid", 32'(s_d_rvalid), 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (s_d_rvalid || s_f_rvalid) cnt++;
    end
    chk("t4_no_rvalid", 32'(cnt), 32'd0);
    mem_lat = 1;
    f_q.push_back(14'h071);
    tick();
    chk("t4_f_gnt_after", 32'(s_f_gnt), 32'd1);
    drain(20, "t4_drain");
    tick();

`ifdef IMEM_ARB_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gnt_en = 1'b0;
    f_q.push_back(14'h080);
    for (int k = 0; k < 3; k++) push_d(1'b0, 4'h0, AW'(14'h090 + k), 32'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("t6_conflict_cnt", conflict_cnt, 32'd10);
    chk("t6_d_win_pre", d_win_cnt, 32'd0);
    gnt_en = 1'b1;
    drain(40, "t6_drain");
    chk("t6_d_win_cnt", d_win_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
